vc_arb_table_sequencer: RTL and testbench



---
 rtl/vc_arb_table_sequencer.sv | 170 +++++++++++++++++
 tb/tb_vc_arb_table_sequencer.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/vc_arb_table_sequencer.sv
// vc_arb_table_sequencer: walks a programmable VC arbitration table and issues valid/ready grants.
// Optional macro VC_ARB_WORK_CONSERVE_EN: idle table slots fall back to round-robin over requesting VCs.
module vc_arb_table_sequencer #(
  parameter  int unsigned NUM_VC = 4,
  parameter  int unsigned DEPTH  = 64,
  localparam int unsigned VC_W   = $clog2(NUM_VC),
  localparam int unsigned ADDR_W = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  enb,
  input  logic                  cfg_load,
  input  logic [DEPTH*VC_W-1:0] cfg_table,
  input  logic [NUM_VC-1:0]     vc_req,
  input  logic                  grant_ready,
  output logic                  grant_valid,
  output logic [VC_W-1:0]       grant_vc,
  output logic [ADDR_W-1:0]     grant_idx,
  output logic                  table_wrap
);

  typedef enum logic [0:0] {
    SLOT  = 1'b0,
    GRANT = 1'b1
  } state_e;

  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(DEPTH - 1);

  state_e                     state_q, state_d;
  logic [DEPTH-1:0][VC_W-1:0] table_q, table_d;
  logic [ADDR_W-1:0]          ptr_q, ptr_d;
  logic                       grant_valid_q, grant_valid_d;
  logic [VC_W-1:0]            grant_vc_q, grant_vc_d;
  logic [ADDR_W-1:0]          grant_idx_q, grant_idx_d;
  logic                       table_wrap_q, table_wrap_d;

  logic [ADDR_W-1:0]          eval_idx;
  logic [VC_W-1:0]            eval_ch;
  logic                       sel_hit;
  logic [VC_W-1:0]            sel_ch;

`ifdef VC_ARB_WORK_CONSERVE_EN
  logic [VC_W-1:0]            rr_q, rr_d;
  logic                       fb_hit;
  logic [VC_W-1:0]            fb_ch;
  logic [VC_W-1:0]            fb_cand;
  logic                       sel_fb;
`endif

  // Slot under evaluation: current pointer, or the next one when a pending grant is being accepted.
  always_comb begin
    eval_idx = ptr_q;
    if (state_q == GRANT && grant_ready) begin
      eval_idx = ptr_q + ADDR_W'(1);
    end
    eval_ch = table_q[eval_idx];
    sel_hit = vc_req[eval_ch];
    sel_ch  = eval_ch;
`ifdef VC_ARB_WORK_CONSERVE_EN
    sel_fb  = 1'b0;
    fb_hit  = 1'b0;
    fb_ch   = '0;
    fb_cand = '0;
    for (int k = 0; k < int'(NUM_VC); k++) begin
      fb_cand = rr_q + VC_W'(k);
      if (!fb_hit && vc_req[fb_cand]) begin
        fb_hit = 1'b1;
        fb_ch  = fb_cand;
      end
    end
    if (!sel_hit && fb_hit) begin
      sel_hit = 1'b1;
      sel_ch  = fb_ch;
      sel_fb  = 1'b1;
    end
`endif
  end

  // Next-state and registered-output logic.
  always_comb begin
    state_d       = state_q;
    table_d       = table_q;
    ptr_d         = ptr_q;
    grant_valid_d = grant_valid_q;
    grant_vc_d    = grant_vc_q;
    grant_idx_d   = grant_idx_q;
    table_wrap_d  = table_wrap_q;
`ifdef VC_ARB_WORK_CONSERVE_EN
    rr_d          = rr_q;
`endif
    if (enb) begin
      table_wrap_d = 1'b0;
      if (cfg_load) begin
        table_d       = cfg_table;
        ptr_d         = '0;
        grant_valid_d = 1'b0;
        state_d       = SLOT;
      end else begin
        case (state_q)
          SLOT: begin
            if (sel_hit) begin
              grant_valid_d = 1'b1;
              grant_vc_d    = sel_ch;
              grant_idx_d   = eval_idx;
              state_d       = GRANT;
`ifdef VC_ARB_WORK_CONSERVE_EN
              if (sel_fb) rr_d = sel_ch + VC_W'(1);
`endif
            end else begin
              ptr_d        = ptr_q + ADDR_W'(1);
              table_wrap_d = (ptr_q == LAST_IDX);
            end
          end
          GRANT: begin
            if (grant_ready) begin
              ptr_d        = eval_idx;
              table_wrap_d = (ptr_q == LAST_IDX);
              if (sel_hit) begin
                grant_vc_d  = sel_ch;
                grant_idx_d = eval_idx;
`ifdef VC_ARB_WORK_CONSERVE_EN
                if (sel_fb) rr_d = sel_ch + VC_W'(1);
`endif
              end else begin
                grant_valid_d = 1'b0;
                state_d       = SLOT;
              end
            end
          end
          default: state_d = SLOT;
        endcase
      end
    end
  end

  // State registers; table resets to the identity pattern i mod NUM_VC.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= SLOT;
      ptr_q         <= '0;
      grant_valid_q <= 1'b0;
      grant_vc_q    <= '0;
      grant_idx_q   <= '0;
      table_wrap_q  <= 1'b0;
      for (int i = 0; i < int'(DEPTH); i++) begin
        table_q[i] <= VC_W'(i % int'(NUM_VC));
      end
`ifdef VC_ARB_WORK_CONSERVE_EN
      rr_q          <= '0;
`endif
    end else begin
      state_q       <= state_d;
      table_q       <= table_d;
      ptr_q         <= ptr_d;
      grant_valid_q <= grant_valid_d;
      grant_vc_q    <= grant_vc_d;
      grant_idx_q   <= grant_idx_d;
      table_wrap_q  <= table_wrap_d;
`ifdef VC_ARB_WORK_CONSERVE_EN
      rr_q          <= rr_d;
`endif
    end
  end

  assign grant_valid = grant_valid_q;
  assign grant_vc    = grant_vc_q;
  assign grant_idx   = grant_idx_q;
  assign table_wrap  = table_wrap_q;

endmodule

// File: tb/tb_vc_arb_table_sequencer.sv
// Scoreboard bench for vc_arb_table_sequencer: a slot-level reference model predicts each cycle's outputs.
module tb_vc_arb_table_sequencer;

  localparam int NUM_VC = 4;
  localparam int DEPTH  = 64;
  localparam int VC_W   = $clog2(NUM_VC);
  localparam int ADDR_W = $clog2(DEPTH);

  logic                  clk;
  logic                  rst_n;
  logic                  enb;
  logic                  cfg_load;
  logic [DEPTH*VC_W-1:0] cfg_table;
  logic [NUM_VC-1:0]     vc_req;
  logic                  grant_ready;
  logic                  grant_valid;
  logic [VC_W-1:0]       grant_vc;
  logic [ADDR_W-1:0]     grant_idx;
  logic                  table_wrap;

  vc_arb_table_sequencer #(.NUM_VC(NUM_VC), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .enb(enb), .cfg_load(cfg_load), .cfg_table(cfg_table),
    .vc_req(vc_req), .grant_ready(grant_ready), .grant_valid(grant_valid),
    .grant_vc(grant_vc), .grant_idx(grant_idx), .table_wrap(table_wrap)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit gv;
    int vc;
    int idx;
    bit wrap;
  } exp_t;

  exp_t exp_q[$];
  int   n_pass  = 0;
  int   n_total = 0;

  // Values applied to the DUT inputs at the next falling edge.
  logic                  s_rst, s_enb, s_cfg, s_rdy;
  logic [NUM_VC-1:0]     s_req;
  logic [DEPTH*VC_W-1:0] s_tbl;

  // Reference model: table contents, slot pointer, the grant on offer, fallback pointer.
  int m_tbl[DEPTH];
  int m_ptr, m_vc, m_idx, m_rr;
  bit m_pend, m_wrap;

  task automatic chk(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
  endtask

  function automatic logic [DEPTH*VC_W-1:0] default_tbl();
    logic [DEPTH*VC_W-1:0] t;
    for (int i = 0; i < DEPTH; i++) t[i*VC_W +: VC_W] = VC_W'(i % NUM_VC);
    return t;
  endfunction

  function automatic logic [DEPTH*VC_W-1:0] rand_tbl();
    logic [DEPTH*VC_W-1:0] t;
    for (int i = 0; i < DEPTH; i++) t[i*VC_W +: VC_W] = VC_W'($urandom_range(0, NUM_VC - 1));
    return t;
  endfunction

  task automatic m_reset();
    for (int i = 0; i < DEPTH; i++) m_tbl[i] = i % NUM_VC;
    m_ptr = 0; m_vc = 0; m_idx = 0; m_rr = 0; m_pend = 0; m_wrap = 0;
  endtask

  // Which channel (if any) slot idx grants under the current requests.
  function automatic bit pick(input int idx, output int ch, output bit fb);
    ch = m_tbl[idx];
    fb = 0;
    if (vc_req[ch]) return 1;
`ifdef VC_ARB_WORK_CONSERVE_EN
    for (int k = 0; k < NUM_VC; k++) begin
      if (vc_req[(m_rr + k) % NUM_VC]) begin
        ch = (m_rr + k) % NUM_VC;
        fb = 1;
        return 1;
      end
    end
`endif
    return 0;
  endfunction

  task automatic m_advance();
    if (m_ptr == DEPTH - 1) m_wrap = 1;
    m_ptr = (m_ptr + 1) % DEPTH;
  endtask

  task automatic m_offer(input int ch, input bit fb);
    m_pend = 1;
    m_vc   = ch;
    m_idx  = m_ptr;
    if (fb) m_rr = (ch + 1) % NUM_VC;
  endtask

  task automatic model_step();
    int   ch;
    bit   fb;
    exp_t e;
    if (!rst_n) m_reset();
    else if (enb) begin
      m_wrap = 0;
      if (cfg_load) begin
        for (int i = 0; i < DEPTH; i++) m_tbl[i] = int'(cfg_table[i*VC_W +: VC_W]);
        m_ptr  = 0;
        m_pend = 0;
      end else if (!m_pend) begin
        if (pick(m_ptr, ch, fb)) m_offer(ch, fb);
        else m_advance();
      end else if (grant_ready) begin
        m_advance();
        if (pick(m_ptr, ch, fb)) m_offer(ch, fb);
        else m_pend = 0;
      end
    end
    e.gv = m_pend; e.vc = m_vc; e.idx = m_idx; e.wrap = m_wrap;
    exp_q.push_back(e);
  endtask

  // Apply staged inputs on the falling edge, then predict the outputs of the following rising edge.
  task automatic cycle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      rst_n = s_rst; enb = s_enb; cfg_load = s_cfg; cfg_table = s_tbl;
      vc_req = s_req; grant_ready = s_rdy;
      @(posedge clk);
      model_step();
    end
  endtask

  // Monitor: compare the DUT outputs with the oldest prediction once per cycle.
  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("grant_valid", int'(grant_valid), int'(e.gv));
        chk("table_wrap", int'(table_wrap), int'(e.wrap));
        if (e.gv) begin
          chk("grant_vc", int'(grant_vc), e.vc);
          chk("grant_idx", int'(grant_idx), e.idx);
        end
      end
    end
  end

  initial begin : stimulus
    rst_n = 1'b0; enb = 1'b0; cfg_load = 1'b0; cfg_table = '0; vc_req = '0; grant_ready = 1'b0;
    s_rst = 1'b0; s_enb = 1'b0; s_cfg = 1'b0; s_tbl = default_tbl(); s_req = '0; s_rdy = 1'b0;
    m_reset();
    #3;
    chk("reset_valid", int'(grant_valid), 0);
    chk("reset_vc", int'(grant_vc), 0);
    chk("reset_idx", int'(grant_idx), 0);
    chk("reset_wrap", int'(table_wrap), 0);
    cycle(2);

    // Default table, all channels requesting, ready held: 0,1,2,3,... with wrap every 64.
    s_rst = 1'b1; s_enb = 1'b1; s_req = '1; s_rdy = 1'b1;
    cycle(140);

    // All entries 3, only channel 3 requesting.
    s_tbl = '1; s_cfg = 1'b1; cycle(1);
    s_cfg = 1'b0; s_req = 4'b1000; cycle(70);

    // Backpressure mid-grant, then requests drop: exactly one transfer.
    s_tbl = default_tbl(); s_cfg = 1'b1; cycle(1);
    s_cfg = 1'b0; s_req = '1; s_rdy = 1'b1; cycle(5);
    s_rdy = 1'b0; cycle(3);
    s_req = '0; s_rdy = 1'b1; cycle(4);

    // Idle slots: only channel 0 requesting on the default table.
    s_req = 4'b0001; cycle(70);

    // Reload while a grant is stalled.
    s_req = '1; s_rdy = 1'b0; cycle(2);
    s_tbl = rand_tbl(); s_cfg = 1'b1; cycle(1);
    s_cfg = 1'b0; s_rdy = 1'b1; cycle(10);

    // Disabled: everything frozen, including a requested reload.
    s_rdy = 1'b0; cycle(2);
    s_enb = 1'b0;
    for (int i = 0; i < 5; i++) begin
      s_req = NUM_VC'($urandom); s_rdy = 1'($urandom); s_cfg = 1'($urandom); s_tbl = rand_tbl();
      cycle(1);
    end
    s_enb = 1'b1; s_cfg = 1'b0; s_rdy = 1'b1; cycle(5);

    // Random traffic with occasional reloads and disabled cycles.
    for (int i = 0; i < 500; i++) begin
      s_enb = ($urandom_range(0, 9) != 0);
      s_cfg = ($urandom_range(0, 49) == 0);
      if (s_cfg) s_tbl = ($urandom_range(0, 1) == 0) ? rand_tbl() : default_tbl();
      s_req = NUM_VC'($urandom);
      s_rdy = ($urandom_range(0, 3) != 0);
      cycle(1);
    end
    s_enb = 1'b1; s_cfg = 1'b0;

    // Asynchronous reset between edges while a grant is pending.
    s_req = '1; s_rdy = 1'b0; cycle(3);
    #2;
    rst_n = 1'b0; s_rst = 1'b0;
    #1;
    chk("async_rst_valid", int'(grant_valid), 0);
    chk("async_rst_vc", int'(grant_vc), 0);
    chk("async_rst_idx", int'(grant_idx), 0);
    chk("async_rst_wrap", int'(table_wrap), 0);
    exp_q.delete();
    m_reset();
    cycle(2);
    s_rst = 1'b1; s_rdy = 1'b1; cycle(12);

    for (int i = 0; i < 10 && exp_q.size() > 0; i++) begin
      @(negedge clk);
      #1;
    end
    if (exp_q.size() > 0) chk("scoreboard_drain", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
